id_stage_fwd: RTL and testbench
===============================

Name: id_stage_fwd

Overview:
Parametrised MIPS-style instruction-decode stage: sits between the fetch register (IF/ID) and execute.
- Reads the register file and selects operands, with forwarding from EX/MEM and MEM/WB.
- Detects load-use and branch-operand hazards; inserts bubbles and stalls fetch.
- Resolves branches and jumps in decode.
- Registers all EX-bound fields into an ID/EX pipeline register with valid, hold and flush.

Parameters:
DATA_W, 32, datapath and PC width (>=32)
RADDR_W, 5, register address width
CTL_W, 12, width of opaque control bundle from the control decoder, passed to EX unmodified

Ports:
clock  input  1  clock
reset  input  1  asynchronous active-low reset
if_id_valid  input  1  IF/ID holds a real instruction
if_id_instruc  input  32  instruction word
if_id_nextpc  input  DATA_W  PC+4 of the instruction
ctl_bundle  input  CTL_W  control decoder output for if_id_instruc
ctl_writereg  input  1  instruction writes a register
ctl_readmem  input  1  instruction is a load
ctl_regdst_rd  input  1  1: dest = instr[15:11]; 0: dest = instr[20:16]
ctl_zeroext  input  1  1: zero-extend imm; 0: sign-extend imm
ctl_brtype  input  2  00 none, 01 jump, 10 beq, 11 bne
ctl_usesrt  input  1  instruction reads rt
id_reg_addra  output  RADDR_W  rs = instr[25:21]
id_reg_addrb  output  RADDR_W  rt = instr[20:16]
reg_id_dataa  input  DATA_W  regfile port A data (combinational)
reg_id_datab  input  DATA_W  regfile port B data
exmem_writereg  input  1  EX/MEM will write
exmem_regdest  input  RADDR_W  EX/MEM dest
exmem_value  input  DATA_W  EX/MEM ALU result
memwb_writereg  input  1  MEM/WB will write
memwb_regdest  input  RADDR_W  MEM/WB dest
memwb_value  input  DATA_W  MEM/WB writeback value
ex_id_stall  input  1  EX cannot accept; hold ID/EX
id_flush  input  1  squash instruction entering ID/EX
id_if_stall  output  1  hold PC and IF/ID
id_if_selpcsource  output  1  take branch/jump target
id_if_target  output  DATA_W  branch or jump target
id_ex_valid  output  1  ID/EX holds real instruction
id_ex_ctl  output  CTL_W  registered ctl_bundle
id_ex_writereg  output  1  registered ctl_writereg, forced 0 when bubble
id_ex_readmem  output  1  registered ctl_readmem, forced 0 when bubble
id_ex_rega  output  DATA_W  forwarded rs value
id_ex_regb  output  DATA_W  forwarded rt value
id_ex_imedext  output  DATA_W  extended immediate
id_ex_shiftamt  output  5  instr[10:6]
id_ex_regdest  output  RADDR_W  destination register

Behaviour:
Reset (async, reset==0):
- All id_ex_* outputs clear to 0 immediately.
- Counter (if enabled) clears to 0.
- Combinational outputs follow their inputs during reset.

Forwarding (combinational), per operand rX:
- Select exmem_value if exmem_writereg && exmem_regdest==rX && rX!=0.
- Else memwb_value under the same rule.
- Else regfile data.
- EX/MEM has priority over MEM/WB.
- Register 0 always reads the regfile.

Hazard:
- A hazard exists when id_ex_valid && id_ex_writereg && id_ex_regdest!=0, the dest matches rs (or rt when ctl_usesrt), and either:
  - id_ex_readmem=1 (load-use), or
  - ctl_brtype is 10/11 (branch needs a value still in EX).
- hazard = above && if_id_valid.
- id_if_stall = hazard | ex_id_stall.

Branch (combinational):
- Immediate extension: sign- or zero-extend per ctl_zeroext.
- Branch target = nextpc + (ext imm << 2). Jump target = {nextpc[DATA_W-1:28], instr[25:0], 2'b00}.
- Compare uses the forwarded operands.
- id_if_selpcsource = if_id_valid && !id_if_stall && (brtype==01 | (brtype==10 && a==b) | (brtype==11 && a!=b)).
- Jumps to register are not handled here.

ID/EX register, per clock edge, priority order:
1. id_flush: valid<=0, writereg<=0, readmem<=0; data fields don't-care.
2. ex_id_stall: all fields hold.
3. hazard: bubble; valid<=0, writereg<=0, readmem<=0.
4. Else load: valid<=if_id_valid, writereg/readmem gated by if_id_valid, and all fields.
- Latency: 1 cycle from IF/ID to ID/EX when no hazard; exactly 1 bubble per load-use or branch hazard.
- Back-to-back hazards stall each cycle until the producer leaves EX.

Optional Feature:
ID_STALL_CNT_EN.
- Defined: adds output id_stall_count [31:0], incrementing on each clock where hazard=1. It saturates at 0xFFFFFFFF and is cleared by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- lw $2 in ID/EX (readmem=1, dest 2); add $3,$2,$4 in IF/ID → id_if_stall=1, next edge id_ex_valid=0. Following cycle the add issues with rega=memwb_value once it is forwarded.
- exmem dest 5 = 0x11, memwb dest 5 = 0x22; add rs=5 → id_ex_rega=0x11. Then exmem_writereg=0 → rega=0x22.
- rs=0 with exmem_regdest=0, exmem_value=0xFFFF → rega = reg_id_dataa (0).
- beq, both operands 7, nextpc=0x100, imm=0xFFFE → selpcsource=1, target=0xF8. bne with the same operands → selpcsource=0.
- ex_id_stall=1 for 3 cycles → id_ex_* unchanged and id_if_stall=1. id_flush together with ex_id_stall → id_ex_valid=0 next edge.
- Reset asserted mid-stall → all id_ex_* =0 without waiting for a clock edge. With ID_STALL_CNT_EN, 4 hazard cycles → id_stall_count=4.

Source files
------------

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: instruction-decode stage for a 5-stage MIPS-style pipeline.
// Reads the register file, forwards operands from EX/MEM and MEM/WB, detects
// load-use / branch-operand hazards, resolves branches and jumps in decode and
// registers EX-bound fields into the ID/EX pipeline register.
// Optional build macro ID_STALL_CNT_EN adds a saturating hazard-cycle counter
// on output id_stall_count.
module id_stage_fwd #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTL_W   = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_id_valid,
  input  logic [31:0]        if_id_instruc,
  input  logic [DATA_W-1:0]  if_id_nextpc,
  input  logic [CTL_W-1:0]   ctl_bundle,
  input  logic               ctl_writereg,
  input  logic               ctl_readmem,
  input  logic               ctl_regdst_rd,
  input  logic               ctl_zeroext,
  input  logic [1:0]         ctl_brtype,
  input  logic               ctl_usesrt,
  output logic [RADDR_W-1:0] id_reg_addra,
  output logic [RADDR_W-1:0] id_reg_addrb,
  input  logic [DATA_W-1:0]  reg_id_dataa,
  input  logic [DATA_W-1:0]  reg_id_datab,
  input  logic               exmem_writereg,
  input  logic [RADDR_W-1:0] exmem_regdest,
  input  logic [DATA_W-1:0]  exmem_value,
  input  logic               memwb_writereg,
  input  logic [RADDR_W-1:0] memwb_regdest,
  input  logic [DATA_W-1:0]  memwb_value,
  input  logic               ex_id_stall,
  input  logic               id_flush,
  output logic               id_if_stall,
  output logic               id_if_selpcsource,
  output logic [DATA_W-1:0]  id_if_target,
  output logic               id_ex_valid,
  output logic [CTL_W-1:0]   id_ex_ctl,
  output logic               id_ex_writereg,
  output logic               id_ex_readmem,
  output logic [DATA_W-1:0]  id_ex_rega,
  output logic [DATA_W-1:0]  id_ex_regb,
  output logic [DATA_W-1:0]  id_ex_imedext,
  output logic [4:0]         id_ex_shiftamt,
  output logic [RADDR_W-1:0] id_ex_regdest
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]        id_stall_count
`endif
);

  // Youngest in-flight writer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [RADDR_W-1:0] r,
    input logic [DATA_W-1:0]  rf_data,
    input logic               exw,
    input logic [RADDR_W-1:0] exd,
    input logic [DATA_W-1:0]  exv,
    input logic               mww,
    input logic [RADDR_W-1:0] mwd,
    input logic [DATA_W-1:0]  mwv
  );
    if (r == '0)                 return rf_data;
    else if (exw && (exd == r))  return exv;
    else if (mww && (mwd == r))  return mwv;
    else                         return rf_data;
  endfunction

  function automatic logic signed [DATA_W-1:0] ext_imm(
    input logic [15:0] imm,
    input logic        zext
  );
    if (zext) return $signed({{(DATA_W-16){1'b0}}, imm});
    else      return $signed({{(DATA_W-16){imm[15]}}, imm});
  endfunction

  logic [RADDR_W-1:0]        rs, rt, dest;
  logic [DATA_W-1:0]         opa, opb;
  logic signed [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]         br_target, j_target;
  logic                      hazard, take;
  logic                      unused_opcode;

  logic               valid_q, valid_d;
  logic [CTL_W-1:0]   ctl_q, ctl_d;
  logic               wr_q, wr_d;
  logic               rm_q, rm_d;
  logic [DATA_W-1:0]  rega_q, rega_d;
  logic [DATA_W-1:0]  regb_q, regb_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [4:0]         sh_q, sh_d;
  logic [RADDR_W-1:0] dest_q, dest_d;

  assign rs            = RADDR_W'(if_id_instruc[25:21]);
  assign rt            = RADDR_W'(if_id_instruc[20:16]);
  assign dest          = ctl_regdst_rd ? RADDR_W'(if_id_instruc[15:11]) : rt;
  assign id_reg_addra  = rs;
  assign id_reg_addrb  = rt;
  assign unused_opcode = ^if_id_instruc[31:26];

  assign opa = fwd_operand(rs, reg_id_dataa, exmem_writereg, exmem_regdest, exmem_value,
                           memwb_writereg, memwb_regdest, memwb_value);
  assign opb = fwd_operand(rt, reg_id_datab, exmem_writereg, exmem_regdest, exmem_value,
                           memwb_writereg, memwb_regdest, memwb_value);

  assign imm_ext   = ext_imm(if_id_instruc[15:0], ctl_zeroext);
  assign br_target = if_id_nextpc + $unsigned(imm_ext <<< 2);
  assign j_target  = {if_id_nextpc[DATA_W-1:28], if_id_instruc[25:0], 2'b00};

  // Hazard: producer still in EX whose result is not yet forwardable to this consumer.
  always_comb begin
    logic producer, src_match;
    producer  = valid_q && wr_q && (dest_q != '0);
    src_match = (dest_q == rs) || (ctl_usesrt && (dest_q == rt));
    hazard    = if_id_valid && producer && src_match && (rm_q || ctl_brtype[1]);
  end

  assign id_if_stall = hazard | ex_id_stall;

  // Branch/jump resolution on forwarded operands; a stalled decode never redirects.
  always_comb begin
    take         = 1'b0;
    id_if_target = br_target;
    unique case (ctl_brtype)
      2'b01: begin take = 1'b1;         id_if_target = j_target; end
      2'b10:       take = (opa == opb);
      2'b11:       take = (opa != opb);
      default:     take = 1'b0;
    endcase
    id_if_selpcsource = if_id_valid && !id_if_stall && take;
  end

  // ID/EX next state: flush beats stall beats bubble beats load.
  always_comb begin
    valid_d = valid_q;  ctl_d  = ctl_q;   wr_d   = wr_q;   rm_d   = rm_q;
    rega_d  = rega_q;   regb_d = regb_q;  imm_d  = imm_q;  sh_d   = sh_q;
    dest_d  = dest_q;
    if (id_flush) begin
      valid_d = 1'b0;  wr_d = 1'b0;  rm_d = 1'b0;
    end else if (ex_id_stall) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;  wr_d = 1'b0;  rm_d = 1'b0;
    end else begin
      valid_d = if_id_valid;
      ctl_d   = ctl_bundle;
      wr_d    = if_id_valid & ctl_writereg;
      rm_d    = if_id_valid & ctl_readmem;
      rega_d  = opa;
      regb_d  = opb;
      imm_d   = $unsigned(imm_ext);
      sh_d    = if_id_instruc[10:6];
      dest_d  = dest;
    end
  end

  // ---- ID/EX pipeline register ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;  ctl_q  <= '0;  wr_q  <= 1'b0;  rm_q <= 1'b0;
      rega_q  <= '0;    regb_q <= '0;  imm_q <= '0;    sh_q <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;  ctl_q  <= ctl_d;   wr_q  <= wr_d;   rm_q <= rm_d;
      rega_q  <= rega_d;   regb_q <= regb_d;  imm_q <= imm_d;  sh_q <= sh_d;
      dest_q  <= dest_d;
    end
  end

  assign id_ex_valid    = valid_q;
  assign id_ex_ctl      = ctl_q;
  assign id_ex_writereg = wr_q;
  assign id_ex_readmem  = rm_q;
  assign id_ex_rega     = rega_q;
  assign id_ex_regb     = regb_q;
  assign id_ex_imedext  = imm_q;
  assign id_ex_shiftamt = sh_q;
  assign id_ex_regdest  = dest_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count hazard cycles, sticking at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Hazard counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign id_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_fwd.sv
// Testbench for id_stage_fwd: table of decode vectors with a scoreboard for the
// registered ID/EX fields, plus hand sequences for stall, flush and reset.
module tb_id_stage_fwd;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_id_valid;
  logic [31:0] if_id_instruc, if_id_nextpc;
  logic [11:0] ctl_bundle;
  logic        ctl_writereg, ctl_readmem, ctl_regdst_rd, ctl_zeroext, ctl_usesrt;
  logic [1:0]  ctl_brtype;
  logic [4:0]  id_reg_addra, id_reg_addrb;
  logic [31:0] reg_id_dataa, reg_id_datab;
  logic        exmem_writereg, memwb_writereg;
  logic [4:0]  exmem_regdest, memwb_regdest;
  logic [31:0] exmem_value, memwb_value;
  logic        ex_id_stall, id_flush;
  logic        id_if_stall, id_if_selpcsource;
  logic [31:0] id_if_target;
  logic        id_ex_valid, id_ex_writereg, id_ex_readmem;
  logic [11:0] id_ex_ctl;
  logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext;
  logic [4:0]  id_ex_shiftamt, id_ex_regdest;
`ifdef ID_STALL_CNT_EN
  logic [31:0] id_stall_count;
`endif

  id_stage_fwd #(.DATA_W(32), .RADDR_W(5), .CTL_W(12)) dut (
    .clock(clock), .reset(reset),
    .if_id_valid(if_id_valid), .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
    .ctl_bundle(ctl_bundle), .ctl_writereg(ctl_writereg), .ctl_readmem(ctl_readmem),
    .ctl_regdst_rd(ctl_regdst_rd), .ctl_zeroext(ctl_zeroext), .ctl_brtype(ctl_brtype),
    .ctl_usesrt(ctl_usesrt),
    .id_reg_addra(id_reg_addra), .id_reg_addrb(id_reg_addrb),
    .reg_id_dataa(reg_id_dataa), .reg_id_datab(reg_id_datab),
    .exmem_writereg(exmem_writereg), .exmem_regdest(exmem_regdest), .exmem_value(exmem_value),
    .memwb_writereg(memwb_writereg), .memwb_regdest(memwb_regdest), .memwb_value(memwb_value),
    .ex_id_stall(ex_id_stall), .id_flush(id_flush),
    .id_if_stall(id_if_stall), .id_if_selpcsource(id_if_selpcsource), .id_if_target(id_if_target),
    .id_ex_valid(id_ex_valid), .id_ex_ctl(id_ex_ctl), .id_ex_writereg(id_ex_writereg),
    .id_ex_readmem(id_ex_readmem), .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb),
    .id_ex_imedext(id_ex_imedext), .id_ex_shiftamt(id_ex_shiftamt),
`ifdef ID_STALL_CNT_EN
    .id_stall_count(id_stall_count),
`endif
    .id_ex_regdest(id_ex_regdest)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic [1:0]  br;
    logic        usesrt, wr, rm, rdst, zext;
    logic [31:0] npc, rfa, rfb;
    logic        exw;  logic [4:0] exd;  logic [31:0] exv;
    logic        mww;  logic [4:0] mwd;  logic [31:0] mwv;
    logic        e_stall, e_sel, chk_tgt;
    logic [31:0] e_tgt;
    logic        e_vld;
    logic [31:0] e_a, e_b, e_imm;
    logic [4:0]  e_sh, e_dest;
  } vec_t;

  typedef struct {
    logic        vld, wr, rm;
    logic [11:0] ctl;
    logic [31:0] a, b, imm;
    logic [4:0]  sh, dest;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive_ctl(input logic [31:0] instr, input logic vld, input logic [1:0] br,
                           input logic usesrt, wr, rm, rdst, zext);
    if_id_instruc = instr;  if_id_valid = vld;   ctl_brtype = br;  ctl_usesrt = usesrt;
    ctl_writereg  = wr;     ctl_readmem = rm;    ctl_regdst_rd = rdst;  ctl_zeroext = zext;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    // instr, vld, br, usesrt, wr, rm, rdst, zext, npc, rfa, rfb, exw, exd, exv, mww, mwd, mwv,
    // e_stall, e_sel, chk_tgt, e_tgt, e_vld, e_a, e_b, e_imm, e_sh, e_dest
    tbl.push_back('{rtype(5'd1,5'd2,5'd3,5'd0,6'h20), 1'b1, 2'b00, 1'b1,1'b1,1'b0,1'b1,1'b0, 32'h10, 32'hA, 32'hB, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'hA,32'hB,32'h1820,5'd0,5'd3});
    tbl.push_back('{itype(6'h23,5'd1,5'd2,16'h0004), 1'b1, 2'b00, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'h14, 32'h100, 32'h77, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h100,32'h77,32'h4,5'd0,5'd2});
    tbl.push_back('{rtype(5'd2,5'd4,5'd3,5'd0,6'h20), 1'b1, 2'b00, 1'b1,1'b1,1'b0,1'b1,1'b0, 32'h18, 32'h99, 32'h44, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,32'h0,32'h0,5'd0,5'd0});
    tbl.push_back('{rtype(5'd2,5'd4,5'd3,5'd0,6'h20), 1'b1, 2'b00, 1'b1,1'b1,1'b0,1'b1,1'b0, 32'h18, 32'h99, 32'h44, 1'b0,5'd0,32'h0, 1'b1,5'd2,32'h55, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h55,32'h44,32'h1820,5'd0,5'd3});
    tbl.push_back('{rtype(5'd5,5'd5,5'd6,5'd3,6'h20), 1'b1, 2'b00, 1'b1,1'b1,1'b0,1'b1,1'b0, 32'h1C, 32'h1, 32'h1, 1'b1,5'd5,32'h11, 1'b1,5'd5,32'h22, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h11,32'h11,32'h30E0,5'd3,5'd6});
    tbl.push_back('{rtype(5'd5,5'd5,5'd6,5'd3,6'h20), 1'b1, 2'b00, 1'b1,1'b1,1'b0,1'b1,1'b0, 32'h20, 32'h1, 32'h1, 1'b0,5'd5,32'h11, 1'b1,5'd5,32'h22, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h22,32'h22,32'h30E0,5'd3,5'd6});
    tbl.push_back('{rtype(5'd0,5'd0,5'd7,5'd0,6'h20), 1'b1, 2'b00, 1'b1,1'b1,1'b0,1'b1,1'b0, 32'h24, 32'h0, 32'h0, 1'b1,5'd0,32'hFFFF, 1'b1,5'd0,32'h1234, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h0,32'h0,32'h3820,5'd0,5'd7});
    tbl.push_back('{itype(6'h04,5'd8,5'd9,16'hFFFE), 1'b1, 2'b10, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h7, 32'h7, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,32'hF8, 1'b1,32'h7,32'h7,32'hFFFFFFFE,5'd31,5'd9});
    tbl.push_back('{itype(6'h05,5'd8,5'd9,16'hFFFE), 1'b1, 2'b11, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h7, 32'h7, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1,32'hF8, 1'b1,32'h7,32'h7,32'hFFFFFFFE,5'd31,5'd9});
    tbl.push_back('{rtype(5'd1,5'd2,5'd10,5'd0,6'h20), 1'b1, 2'b00, 1'b1,1'b1,1'b0,1'b1,1'b0, 32'h104, 32'h3, 32'h4, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h3,32'h4,32'h5020,5'd0,5'd10});
    tbl.push_back('{itype(6'h05,5'd10,5'd0,16'h0001), 1'b1, 2'b11, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h200, 32'h0, 32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0,32'h0, 1'b0,32'h0,32'h0,32'h0,5'd0,5'd0});
    tbl.push_back('{itype(6'h05,5'd10,5'd0,16'h0001), 1'b1, 2'b11, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h200, 32'h0, 32'h0, 1'b1,5'd10,32'h33, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,32'h204, 1'b1,32'h33,32'h0,32'h1,5'd0,5'd0});
    tbl.push_back('{jtype(6'h02,26'h40), 1'b1, 2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h3000_0010, 32'h0, 32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,32'h3000_0100, 1'b1,32'h0,32'h0,32'h40,5'd1,5'd0});
    tbl.push_back('{rtype(5'd1,5'd2,5'd14,5'd0,6'h20), 1'b0, 2'b01, 1'b0,1'b1,1'b1,1'b1,1'b0, 32'h40, 32'h1, 32'h2, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,32'h0,32'h0,5'd0,5'd0});
    tbl.push_back('{itype(6'h0D,5'd1,5'd11,16'h8000), 1'b1, 2'b00, 1'b0,1'b1,1'b0,1'b0,1'b1, 32'h44, 32'h5, 32'h6, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h5,32'h6,32'h8000,5'd0,5'd11});
    tbl.push_back('{itype(6'h23,5'd3,5'd12,16'h0000), 1'b1, 2'b00, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'h48, 32'h8, 32'h9, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h8,32'h9,32'h0,5'd0,5'd12});
    tbl.push_back('{itype(6'h08,5'd1,5'd12,16'h0005), 1'b1, 2'b00, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h4C, 32'h10, 32'h20, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,32'h0, 1'b1,32'h10,32'h20,32'h5,5'd0,5'd12});

    // Reset state
    reset = 1'b0;  ex_id_stall = 1'b0;  id_flush = 1'b0;  ctl_bundle = '0;
    drive_ctl(32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if_id_nextpc = '0;  reg_id_dataa = '0;  reg_id_datab = '0;
    exmem_writereg = 1'b0;  exmem_regdest = '0;  exmem_value = '0;
    memwb_writereg = 1'b0;  memwb_regdest = '0;  memwb_value = '0;
    #12;
    check("rst valid", {31'b0, id_ex_valid}, 32'h0);
    check("rst writereg", {31'b0, id_ex_writereg}, 32'h0);
    check("rst readmem", {31'b0, id_ex_readmem}, 32'h0);
    check("rst rega", id_ex_rega, 32'h0);
    check("rst regdest", {27'b0, id_ex_regdest}, 32'h0);
    reset = 1'b1;

    // Table vectors
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive_ctl(v.instr, v.vld, v.br, v.usesrt, v.wr, v.rm, v.rdst, v.zext);
      ctl_bundle   = 12'h5A0 ^ 12'(i);
      if_id_nextpc = v.npc;  reg_id_dataa = v.rfa;  reg_id_datab = v.rfb;
      exmem_writereg = v.exw;  exmem_regdest = v.exd;  exmem_value = v.exv;
      memwb_writereg = v.mww;  memwb_regdest = v.mwd;  memwb_value = v.mwv;
      #1;
      check($sformatf("v%0d if_stall", i), {31'b0, id_if_stall}, {31'b0, v.e_stall});
      check($sformatf("v%0d selpc", i), {31'b0, id_if_selpcsource}, {31'b0, v.e_sel});
      if (v.chk_tgt) check($sformatf("v%0d target", i), id_if_target, v.e_tgt);
      check($sformatf("v%0d addra", i), {27'b0, id_reg_addra}, {27'b0, v.instr[25:21]});
      check($sformatf("v%0d addrb", i), {27'b0, id_reg_addrb}, {27'b0, v.instr[20:16]});
      e.vld = v.e_vld;  e.wr = v.e_vld & v.wr;  e.rm = v.e_vld & v.rm;  e.ctl = ctl_bundle;
      e.a = v.e_a;  e.b = v.e_b;  e.imm = v.e_imm;  e.sh = v.e_sh;  e.dest = v.e_dest;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        check($sformatf("v%0d scoreboard empty", i), 32'h0, 32'h1);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d ex_valid", i), {31'b0, id_ex_valid}, {31'b0, e.vld});
        check($sformatf("v%0d ex_writereg", i), {31'b0, id_ex_writereg}, {31'b0, e.wr});
        check($sformatf("v%0d ex_readmem", i), {31'b0, id_ex_readmem}, {31'b0, e.rm});
        if (e.vld) begin
          check($sformatf("v%0d ex_ctl", i), {20'b0, id_ex_ctl}, {20'b0, e.ctl});
          check($sformatf("v%0d ex_rega", i), id_ex_rega, e.a);
          check($sformatf("v%0d ex_regb", i), id_ex_regb, e.b);
          check($sformatf("v%0d ex_imm", i), id_ex_imedext, e.imm);
          check($sformatf("v%0d ex_shamt", i), {27'b0, id_ex_shiftamt}, {27'b0, e.sh});
          check($sformatf("v%0d ex_regdest", i), {27'b0, id_ex_regdest}, {27'b0, e.dest});
        end
      end
    end

    // EX back-pressure: ID/EX holds the addi for three cycles
    drive_ctl(rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h20), 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    ex_id_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("hold%0d if_stall", k), {31'b0, id_if_stall}, 32'h1);
      @(posedge clock);
      #1;
      check($sformatf("hold%0d valid", k), {31'b0, id_ex_valid}, 32'h1);
      check($sformatf("hold%0d writereg", k), {31'b0, id_ex_writereg}, 32'h1);
      check($sformatf("hold%0d regdest", k), {27'b0, id_ex_regdest}, 32'd12);
      check($sformatf("hold%0d imm", k), id_ex_imedext, 32'h5);
      check($sformatf("hold%0d rega", k), id_ex_rega, 32'h10);
    end
    // Flush overrides stall
    id_flush = 1'b1;
    #1;
    check("flush if_stall", {31'b0, id_if_stall}, 32'h1);
    @(posedge clock);
    #1;
    check("flush valid", {31'b0, id_ex_valid}, 32'h0);
    check("flush writereg", {31'b0, id_ex_writereg}, 32'h0);
    id_flush = 1'b0;  ex_id_stall = 1'b0;

    // Reset asserted while stalled clears ID/EX without a clock edge
    @(posedge clock);
    #1;
    check("preload valid", {31'b0, id_ex_valid}, 32'h1);
    check("preload regdest", {27'b0, id_ex_regdest}, 32'd13);
    ex_id_stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async rst valid", {31'b0, id_ex_valid}, 32'h0);
    check("async rst writereg", {31'b0, id_ex_writereg}, 32'h0);
    check("async rst rega", id_ex_rega, 32'h0);
    check("async rst regdest", {27'b0, id_ex_regdest}, 32'h0);
    check("async rst ctl", {20'b0, id_ex_ctl}, 32'h0);
    check("rst addra follows", {27'b0, id_reg_addra}, 32'd1);
`ifdef ID_STALL_CNT_EN
    check("rst stall_count", id_stall_count, 32'h0);
`endif
    #1;
    reset = 1'b1;  ex_id_stall = 1'b0;

`ifdef ID_STALL_CNT_EN
    // Load in EX, dependent add held by back-pressure: four hazard cycles
    drive_ctl(itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    drive_ctl(rtype(5'd2, 5'd4, 5'd3, 5'd0, 6'h20), 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    ex_id_stall = 1'b1;
    for (int k = 0; k < 4; k++) @(posedge clock);
    #1;
    check("stall_count 4", id_stall_count, 32'd4);
    check("cnt if_stall", {31'b0, id_if_stall}, 32'h1);
    ex_id_stall = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
